// File: rtl/grey_decode6.sv
// grey_decode6: receive side of a Gray-coded counter crossing clock domains.
// Synchronises the incoming code, decodes it to binary, classifies each sampled
// change as a legal single-bit step or an illegal multi-bit jump, and keeps
// saturating step/error counts for the logic analyser.
module grey_decode6 #(
   parameter int WIDTH       = 6,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] grey_in,
   input  logic             clr,
   output logic [WIDTH-1:0] bin,
   output logic             valid,
   output logic             dir,
   output logic             wrap,
   output logic [CNT_W-1:0] step_cnt,
   output logic [7:0]       err_cnt,
   output logic             err
);

   localparam int FW = $clog2(SYNC_STAGES + 1);
   localparam logic [WIDTH-1:0] MAXV = {WIDTH{1'b1}};

   typedef enum logic {INIT, TRACK} state_t;

   state_t                                 state_q, state_d;
   logic [FW-1:0]                          flush_q, flush_d;
   logic [SYNC_STAGES-1:0][WIDTH-1:0]      sync_q;
   logic [WIDTH-1:0]                       grey_q, grey_d;
   logic [WIDTH-1:0]                       bin_q, bin_d;
   logic                                   valid_q, valid_d;
   logic                                   dir_q, dir_d;
   logic                                   wrap_q, wrap_d;
   logic [CNT_W-1:0]                       step_q, step_d;
   logic [7:0]                             errc_q, errc_d;
   logic                                   err_q, err_d;

   logic [WIDTH-1:0] grey_s, dec_s, diff;
   logic             one_bit, multi_bit;

   // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
   function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

   assign grey_s    = sync_q[SYNC_STAGES-1];
   assign dec_s     = g2b(grey_s);
   assign diff      = grey_s ^ grey_q;
   // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero.
   assign one_bit   = (diff != '0) && ((diff & (diff - WIDTH'(1))) == '0);
   assign multi_bit = (diff != '0) && !one_bit;

   // Synchroniser chain for the foreign-domain Gray code.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= grey_in;
         for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      end
   end

   // State, tracking registers, registered outputs and counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= INIT;
         flush_q <= '0;
         grey_q  <= '0;
         bin_q   <= '0;
         valid_q <= 1'b0;
         dir_q   <= 1'b0;
         wrap_q  <= 1'b0;
         step_q  <= '0;
         errc_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         flush_q <= flush_d;
         grey_q  <= grey_d;
         bin_q   <= bin_d;
         valid_q <= valid_d;
         dir_q   <= dir_d;
         wrap_q  <= wrap_d;
         step_q  <= step_d;
         errc_q  <= errc_d;
         err_q   <= err_d;
      end
   end

   // Next state: flush the synchroniser, then classify each sampled change.
   always_comb begin
      state_d = state_q;
      flush_d = flush_q;
      grey_d  = grey_q;
      bin_d   = bin_q;
      valid_d = 1'b0;
      dir_d   = dir_q;
      wrap_d  = 1'b0;
      step_d  = step_q;
      errc_d  = errc_q;
      err_d   = err_q;
      case (state_q)
         INIT: begin
            // Sync flops still hold reset zeros until flushed; the first real
            // code is adopted silently, whatever its value.
            if (flush_q == FW'(SYNC_STAGES)) begin
               grey_d  = grey_s;
               bin_d   = dec_s;
               state_d = TRACK;
            end else begin
               flush_d = flush_q + FW'(1);
            end
         end
         TRACK: begin
            if (one_bit) begin
               grey_d  = grey_s;
               bin_d   = dec_s;
               valid_d = 1'b1;
               dir_d   = (dec_s == bin_q + WIDTH'(1));
               wrap_d  = ((bin_q == MAXV) && (dec_s == '0)) ||
                         ((bin_q == '0) && (dec_s == MAXV));
               if (step_q != {CNT_W{1'b1}}) step_d = step_q + CNT_W'(1);
            end else if (multi_bit) begin
               // Resynchronise to whatever arrived so one glitch costs one error.
               grey_d = grey_s;
               bin_d  = dec_s;
               err_d  = 1'b1;
               if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
            end
         end
         default: state_d = INIT;
      endcase
      // Clear overrides any same-cycle count/err update; bin and pulses unaffected.
      if (clr) begin
         step_d = '0;
         errc_d = '0;
         err_d  = 1'b0;
      end
   end

   assign bin      = bin_q;
   assign valid    = valid_q;
   assign dir      = dir_q;
   assign wrap     = wrap_q;
   assign step_cnt = step_q;
   assign err_cnt  = errc_q;
   assign err      = err_q;

endmodule

// File: tb/tb_grey_decode6.sv
// Directed bench for grey_decode6: expected legal steps go into a scoreboard
// queue as they are driven and are popped when the DUT pulses valid.
module tb_grey_decode6;

   logic        clk, rst, clr;
   logic [5:0]  grey_in, bin;
   logic        valid, dir, wrap, err;
   logic [15:0] step_cnt;
   logic [7:0]  err_cnt;

   grey_decode6 #(.WIDTH(6), .SYNC_STAGES(2), .CNT_W(16)) dut (
      .clk(clk), .rst(rst), .grey_in(grey_in), .clr(clr),
      .bin(bin), .valid(valid), .dir(dir), .wrap(wrap),
      .step_cnt(step_cnt), .err_cnt(err_cnt), .err(err)
   );

   typedef struct { logic [5:0] b; logic d; logic w; } exp_t;
   exp_t sb[$];

   int n_chk = 0, n_pass = 0, n_valid = 0, n_wrap = 0;
   logic [5:0]  m_g = '0, m_b = '0;
   logic [15:0] m_step = '0;
   logic [7:0]  m_errc = '0;
   logic        m_err = 1'b0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [5:0] g2b(input logic [5:0] g);
      logic [5:0] b = g;
      for (int i = 1; i < 6; i++) b = b ^ (g >> i);
      return b;
   endfunction

   function automatic logic [5:0] b2g(input logic [5:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Drive one code, update the reference model, queue an expected pulse if legal.
   task automatic step(input logic [5:0] g, input int wait_cyc);
      logic [5:0] nb;
      exp_t e;
      nb = g2b(g);
      if ($countones(g ^ m_g) == 1) begin
         e.b = nb;
         e.d = (nb == 6'(m_b + 6'd1));
         e.w = ((m_b == 6'd63) && (nb == 6'd0)) || ((m_b == 6'd0) && (nb == 6'd63));
         sb.push_back(e);
         if (m_step != 16'hFFFF) m_step = m_step + 16'd1;
      end else if (g != m_g) begin
         m_err = 1'b1;
         if (m_errc != 8'hFF) m_errc = m_errc + 8'd1;
      end
      m_g = g;
      m_b = nb;
      grey_in = g;
      tick(wait_cyc);
   endtask

   // Scoreboard consumer: every valid pulse must match the oldest queued step.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && valid) begin
         n_valid++;
         if (wrap) n_wrap++;
         check("sb_nonempty_at_valid", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            check("sb_bin", bin, e.b);
            check("sb_dir", dir, e.d);
            check("sb_wrap", wrap, e.w);
         end
      end
   end

   initial begin
      rst = 1'b1; clr = 1'b0; grey_in = '0;
      tick(2);
      // Reset state
      check("rst_bin", bin, 0);
      check("rst_valid", valid, 0);
      check("rst_step", step_cnt, 0);
      check("rst_errcnt", err_cnt, 0);
      check("rst_err", err, 0);
      rst = 1'b0;
      tick(5);
      check("init_valid", valid, 0);
      check("init_bin", bin, 0);

      // Full up walk 1..63,0 one code per 4 clocks
      for (int b = 1; b <= 64; b++) step(b2g(6'(b)), 4);
      check("walk_pulses", n_valid, 64);
      check("walk_wraps", n_wrap, 1);
      check("walk_step", step_cnt, 64);
      check("walk_err", err, 0);
      check("walk_errcnt", err_cnt, 0);
      check("walk_bin", bin, 0);
      check("walk_sb_drained", sb.size(), 0);

      // Latency: change just after edge t, valid at t+3 only
      begin
         exp_t e;
         e.b = 6'd1; e.d = 1'b1; e.w = 1'b0;
         sb.push_back(e);
         m_g = 6'b000001; m_b = 6'd1; m_step = m_step + 16'd1;
         grey_in = 6'b000001;
         tick(1); check("lat_t1_valid", valid, 0);
         tick(1); check("lat_t2_valid", valid, 0);
         tick(1); check("lat_t3_valid", valid, 1);
         check("lat_t3_bin", bin, 1);
         tick(1); check("lat_t4_valid", valid, 0);
      end

      // Illegal jump 000001 -> 000111
      step(6'b000111, 4);
      check("jump_bin", bin, 5);
      check("jump_err", err, 1);
      check("jump_errcnt", err_cnt, 1);
      check("jump_step", step_cnt, m_step);

      // Down steps, then 0 -> max wrap
      step(6'b000011, 4);
      step(6'b000001, 4);
      check("down_bin", bin, 1);
      check("down_dir", dir, 0);
      step(6'b000000, 4);
      step(6'b100000, 4);
      check("dnwrap_bin", bin, 63);
      check("dnwrap_dir", dir, 0);
      check("dnwrap_count", n_wrap, 2);
      check("down_step", step_cnt, m_step);
      check("down_sb_drained", sb.size(), 0);

      // clr on the same edge as an illegal jump
      grey_in = 6'b100011; m_g = 6'b100011; m_b = g2b(6'b100011);
      tick(2);
      clr = 1'b1;
      tick(1);
      clr = 1'b0;
      m_err = 1'b0; m_errc = '0; m_step = '0;
      check("clr_err", err, 0);
      check("clr_errcnt", err_cnt, 0);
      check("clr_step", step_cnt, 0);
      check("clr_bin", bin, 61);

      // 260 illegal jumps saturate err_cnt
      for (int i = 0; i < 260; i++) step((i % 2 == 0) ? 6'b100000 : 6'b100011, 2);
      tick(4);
      check("sat_errcnt", err_cnt, 255);
      check("sat_model", err_cnt, m_errc);
      check("sat_err", err, 1);
      check("sat_step", step_cnt, 0);

      // Non-zero code present through reset is adopted without error
      rst = 1'b1; grey_in = 6'b100000;
      sb.delete();
      tick(2);
      check("rst2_bin", bin, 0);
      check("rst2_errcnt", err_cnt, 0);
      rst = 1'b0;
      m_g = 6'b100000; m_b = 6'd63; m_step = '0; m_errc = '0; m_err = 1'b0;
      tick(5);
      check("first_bin", bin, 63);
      check("first_valid", valid, 0);
      check("first_err", err, 0);
      step(6'b100001, 4);
      step(6'b100011, 4);
      check("post_step", step_cnt, 2);
      check("post_bin", bin, 61);

      // Async reset mid-walk
      grey_in = 6'b100010;
      tick(2);
      #2 rst = 1'b1;
      #1;
      check("async_bin", bin, 0);
      check("async_step", step_cnt, 0);
      check("async_valid", valid, 0);
      check("async_err", err, 0);
      sb.delete();
      tick(2);
      rst = 1'b0;
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
